ahb2apb_mux_bridge: RTL and testbench
=====================================

// Module: ahb2apb_mux_bridge
// PURPOSE
//  Next-gen AHB-Lite to APB4 bridge, single clock domain (HCLK), APB stepped by PCLKEN.
//  Decodes NUM_PSEL APB slaves from address, honours PREADY wait states, maps PSLVERR
//  to a two-cycle AHB ERROR response, and generates PSTRB from HSIZE/HADDR and PPROT from HPROT.
//  Sits between the AHB interconnect slave port and the APB peripheral cluster.
// PARAMETERS
//  ADDRWIDTH  16  AHB/APB address width
//  DATAWIDTH  32  data width; 32 or 64; PSTRB width = DATAWIDTH/8
//  NUM_PSEL   4   number of APB slaves (1..16)
//  PSEL_LSB   12  slave index = HADDR[PSEL_LSB +: clog2(NUM_PSEL)] (clog2 floored at 1)
// PORTS
//  HCLK       in   1              clock
//  HRESETn    in   1              async reset, active low
//  HSEL       in   1              AHB slave select
//  HADDR      in   ADDRWIDTH      AHB address
//  HTRANS     in   2              AHB transfer type
//  HWRITE     in   1              AHB write
//  HSIZE      in   3              AHB size
//  HPROT      in   4              AHB protection
//  HWDATA     in   DATAWIDTH      AHB write data (data phase)
//  HREADY     in   1              AHB bus ready
//  HREADYOUT  out  1              slave ready
//  HRDATA     out  DATAWIDTH      read data (registered)
//  HRESP      out  1              0=OKAY, 1=ERROR
//  PCLKEN     in   1              APB clock enable; APB state advances only when 1
//  PSEL       out  NUM_PSEL       one-hot APB select
//  PENABLE    out  1              APB enable
//  PADDR      out  ADDRWIDTH      APB address, bits[1:0] forced 0
//  PWRITE     out  1              APB write
//  PWDATA     out  DATAWIDTH      APB write data
//  PSTRB      out  DATAWIDTH/8    APB write strobes
//  PPROT      out  3              APB protection
//  PREADY     in   NUM_PSEL       per-slave ready
//  PSLVERR    in   NUM_PSEL       per-slave error
//  PRDATA     in   NUM_PSEL*DATAWIDTH  per-slave read data, slave i at [i*DATAWIDTH +: DATAWIDTH]
//  APBACTIVE  out  1              high whenever state != IDLE (APB clock-gating hint)
// BEHAVIOUR
//  - Reset: state IDLE; HREADYOUT=1, HRESP=0, HRDATA=0, PSEL=0, PENABLE=0, PADDR=0,
//    PWRITE=0, PWDATA=0, PSTRB=0, PPROT=0, APBACTIVE=0. Reset mid-transfer aborts immediately.
//  - valid = HSEL & HTRANS[1] & HREADY. Sampled only in IDLE and ERR2; elsewhere ignored.
//  - On valid: register addr, write, size, prot, slave index; go WAIT.
//  - States/transitions (all APB moves gated by PCLKEN):
//    IDLE : valid -> WAIT.
//    WAIT : index >= NUM_PSEL -> ERR1 (no PSEL ever asserted);
//           else PCLKEN -> SETUP; capture PWDATA<=HWDATA, drive PADDR/PWRITE/PSTRB/PPROT.
//    SETUP: PCLKEN -> ACCESS.
//    ACCESS: PCLKEN & PREADY[idx] -> ERR1 if PSLVERR[idx], else IDLE; else stay.
//            HRDATA <= PRDATA[idx] on the completing edge (reads and errors).
//    ERR1 -> ERR2 unconditionally; ERR2 -> WAIT if valid, else IDLE.
//  - Outputs: PSEL[idx]=1 in SETUP,ACCESS; PENABLE=1 in ACCESS only.
//    HREADYOUT=0 in WAIT,SETUP,ACCESS,ERR1; 1 in IDLE,ERR2. HRESP=1 in ERR1,ERR2.
//  - APB address/control held stable from SETUP through ACCESS.
//  - Latency: PCLKEN=1, PREADY=1 -> 3 wait states (HREADYOUT low 3 cycles), OKAY on 4th data-phase cycle.
//  - PSTRB (writes): byte -> 1<<HADDR[k-1:0]; half -> 2'b11<<{HADDR[k-1:1],1'b0};
//    word -> 4'hF<<(4*HADDR[k-1]) if 64-bit; dword/larger -> all ones. k=log2(DATAWIDTH/8).
//    PSTRB=0 for reads.
//  - PPROT = {~HPROT[0], 1'b0, HPROT[1]} (instr, secure, privileged).
//  - HTRANS IDLE/BUSY or HSEL=0: OKAY, no APB activity.
//  - PREADY/PSLVERR of non-selected slaves ignored.
// TESTING
//  - Write 0xA5A5_1234 to 0x1004 (slave 1), word, PCLKEN=1, PREADY=1 -> PSEL=4'b0010 one SETUP + one ACCESS cycle;
//    PADDR=0x1004, PSTRB=4'hF; HREADYOUT low exactly 3 cycles.
//  - Read 0x2008, slave 2 PRDATA=0xDEADBEEF, PREADY low 2 ACCESS cycles -> HREADYOUT low 5 cycles, HRDATA=0xDEADBEEF, HRESP=0.
//  - Byte write to 0x0003 -> PSTRB=4'b1000; halfword write to 0x0002 -> PSTRB=4'b1100; read -> PSTRB=0.
//  - PSLVERR=1 with PREADY on slave 3 -> HRESP=1 for 2 cycles, HREADYOUT 0 then 1; next valid in ERR2 accepted.
//  - PCLKEN high every 3rd cycle -> PSEL/PENABLE change only on PCLKEN edges; data correct.
//  - NUM_PSEL=3, access to 0x3000 -> no PSEL; ERROR response. HRESETn low during ACCESS -> all reset values next.

Source files
------------

// File: rtl/ahb2apb_mux_bridge.sv
// AHB-Lite to APB4 bridge: decodes NUM_PSEL slaves, PCLKEN-stepped APB, PSLVERR -> two-cycle ERROR.
// Latency: 3 AHB wait states minimum (PCLKEN=1, PREADY=1); backpressure via HREADYOUT held low.
module ahb2apb_mux_bridge #(
   parameter int ADDRWIDTH = 16,
   parameter int DATAWIDTH = 32,
   parameter int NUM_PSEL  = 4,
   parameter int PSEL_LSB  = 12
) (
   input  logic                          HCLK,
   input  logic                          HRESETn,
   input  logic                          HSEL,
   input  logic [ADDRWIDTH-1:0]          HADDR,
   input  logic [1:0]                    HTRANS,
   input  logic                          HWRITE,
   input  logic [2:0]                    HSIZE,
   input  logic [3:0]                    HPROT,
   input  logic [DATAWIDTH-1:0]          HWDATA,
   input  logic                          HREADY,
   output logic                          HREADYOUT,
   output logic [DATAWIDTH-1:0]          HRDATA,
   output logic                          HRESP,
   input  logic                          PCLKEN,
   output logic [NUM_PSEL-1:0]           PSEL,
   output logic                          PENABLE,
   output logic [ADDRWIDTH-1:0]          PADDR,
   output logic                          PWRITE,
   output logic [DATAWIDTH-1:0]          PWDATA,
   output logic [DATAWIDTH/8-1:0]        PSTRB,
   output logic [2:0]                    PPROT,
   input  logic [NUM_PSEL-1:0]           PREADY,
   input  logic [NUM_PSEL-1:0]           PSLVERR,
   input  logic [NUM_PSEL*DATAWIDTH-1:0] PRDATA,
   output logic                          APBACTIVE
);
   localparam int SW = DATAWIDTH / 8;
   localparam int K  = $clog2(SW);
   localparam int IW = (NUM_PSEL > 1) ? $clog2(NUM_PSEL) : 1;

   typedef enum logic [2:0] {IDLE, WAIT, SETUP, ACCESS, ERR1, ERR2} state_t;

   state_t                 state, nxt;
   logic [ADDRWIDTH-1:0]   addr_q;
   logic                   write_q;
   logic [2:0]             size_q;
   logic [1:0]             prot_q;
   logic [IW-1:0]          idx_q;
   logic                   valid, idx_ok, done, sel_err;
   logic [SW-1:0]          strb;
   logic                   unused_ok;

   assign unused_ok = &{1'b0, HPROT[3:2]};
   assign valid     = HSEL & ((HTRANS == 2'b10) | (HTRANS == 2'b11)) & HREADY;
   assign idx_ok    = 32'(idx_q) < NUM_PSEL;
   assign done      = PCLKEN & PREADY[idx_q];
   assign sel_err   = PSLVERR[idx_q];

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (valid) nxt = WAIT;
         WAIT:    if (!idx_ok) nxt = ERR1;
                  else if (PCLKEN) nxt = SETUP;
         SETUP:   if (PCLKEN) nxt = ACCESS;
         ACCESS:  if (done) nxt = sel_err ? ERR1 : IDLE;
         ERR1:    nxt = ERR2;
         ERR2:    nxt = valid ? WAIT : IDLE;
         default: nxt = IDLE;
      endcase
   end

   // Strobes follow the AHB size/alignment of the captured address phase.
   always_comb begin
      strb = '1;
      case (size_q)
         3'd0: strb = SW'(1) << addr_q[K-1:0];
         3'd1: strb = SW'(3) << {addr_q[K-1:1], 1'b0};
         3'd2: if (SW == 8) strb = SW'(4'hF) << {addr_q[K-1], 2'b00};
         default: ;
      endcase
      if (!write_q) strb = '0;
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state     <= IDLE;
         addr_q    <= '0;
         write_q   <= 1'b0;
         size_q    <= '0;
         prot_q    <= '0;
         idx_q     <= '0;
         HREADYOUT <= 1'b1;
         HRESP     <= 1'b0;
         HRDATA    <= '0;
         PSEL      <= '0;
         PENABLE   <= 1'b0;
         PADDR     <= '0;
         PWRITE    <= 1'b0;
         PWDATA    <= '0;
         PSTRB     <= '0;
         PPROT     <= '0;
         APBACTIVE <= 1'b0;
      end else begin
         state     <= nxt;
         APBACTIVE <= (nxt != IDLE);
         HREADYOUT <= (nxt == IDLE) || (nxt == ERR2);
         HRESP     <= (nxt == ERR1) || (nxt == ERR2);
         PENABLE   <= (nxt == ACCESS);
         PSEL      <= ((nxt == SETUP) || (nxt == ACCESS)) ? (NUM_PSEL'(1) << idx_q) : '0;
         if (((state == IDLE) || (state == ERR2)) && valid) begin
            addr_q  <= HADDR;
            write_q <= HWRITE;
            size_q  <= HSIZE;
            prot_q  <= HPROT[1:0];
            idx_q   <= HADDR[PSEL_LSB +: IW];
         end
         // APB address/control only move on entry to SETUP, so they stay put through ACCESS.
         if ((state == WAIT) && idx_ok && PCLKEN) begin
            PADDR  <= {addr_q[ADDRWIDTH-1:2], 2'b00};
            PWRITE <= write_q;
            PWDATA <= HWDATA;
            PSTRB  <= strb;
            PPROT  <= {~prot_q[0], 1'b0, prot_q[1]};
         end
         if ((state == ACCESS) && done && (!write_q || sel_err))
            HRDATA <= PRDATA[idx_q*DATAWIDTH +: DATAWIDTH];
      end
   end
endmodule

// File: tb/tb_ahb2apb_mux_bridge.sv
// Directed bench for ahb2apb_mux_bridge: a 4-slave instance plus a 3-slave instance for decode errors.
module tb_ahb2apb_mux_bridge;
   logic        HCLK = 1'b0;
   logic        HRESETn = 1'b0;
   logic        hsel_m = 1'b0, hsel_3 = 1'b0;
   logic [15:0] HADDR = '0;
   logic [1:0]  HTRANS = '0;
   logic        HWRITE = 1'b0;
   logic [2:0]  HSIZE = '0;
   logic [3:0]  HPROT = '0;
   logic [31:0] HWDATA = '0;
   logic        HREADY = 1'b1;
   logic        PCLKEN;

   logic        hreadyout, hresp, penable, pwrite, apbactive;
   logic [31:0] hrdata, pwdata;
   logic [3:0]  psel, pstrb;
   logic [15:0] paddr;
   logic [2:0]  pprot;
   logic        hreadyout_3, hresp_3, penable_3, pwrite_3, apbactive_3;
   logic [31:0] hrdata_3, pwdata_3;
   logic [2:0]  psel_3, pprot_3;
   logic [3:0]  pstrb_3;
   logic [15:0] paddr_3;

   logic [3:0]   pready, pslverr = '0;
   logic [127:0] prdata = '0;
   int           acc_cnt = 0, wait_n = 0, ccnt = 0;
   bit           div3 = 0, watch = 0, cur3 = 0;
   logic         pclk_s = 1'b1;
   logic [3:0]   psel_prev = '0;
   logic         pen_prev = 1'b0;
   int           viol = 0;
   int           checks = 0, errors = 0;

   always #5 HCLK = ~HCLK;

   ahb2apb_mux_bridge #(.ADDRWIDTH(16), .DATAWIDTH(32), .NUM_PSEL(4), .PSEL_LSB(12)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel_m), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HSIZE(HSIZE), .HPROT(HPROT), .HWDATA(HWDATA), .HREADY(HREADY),
      .HREADYOUT(hreadyout), .HRDATA(hrdata), .HRESP(hresp), .PCLKEN(PCLKEN),
      .PSEL(psel), .PENABLE(penable), .PADDR(paddr), .PWRITE(pwrite), .PWDATA(pwdata),
      .PSTRB(pstrb), .PPROT(pprot), .PREADY(pready), .PSLVERR(pslverr), .PRDATA(prdata),
      .APBACTIVE(apbactive));

   ahb2apb_mux_bridge #(.ADDRWIDTH(16), .DATAWIDTH(32), .NUM_PSEL(3), .PSEL_LSB(12)) dut3 (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel_3), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HSIZE(HSIZE), .HPROT(HPROT), .HWDATA(HWDATA), .HREADY(HREADY),
      .HREADYOUT(hreadyout_3), .HRDATA(hrdata_3), .HRESP(hresp_3), .PCLKEN(PCLKEN),
      .PSEL(psel_3), .PENABLE(penable_3), .PADDR(paddr_3), .PWRITE(pwrite_3), .PWDATA(pwdata_3),
      .PSTRB(pstrb_3), .PPROT(pprot_3), .PREADY(pready[2:0]), .PSLVERR(pslverr[2:0]),
      .PRDATA(prdata[95:0]), .APBACTIVE(apbactive_3));

   // Slave ready model: PREADY rises after wait_n ACCESS cycles.
   assign pready = (acc_cnt >= wait_n) ? 4'hF : 4'h0;
   assign PCLKEN = div3 ? (ccnt == 2) : 1'b1;
   always @(posedge HCLK) begin
      acc_cnt <= (penable | penable_3) ? acc_cnt + 1 : 0;
      ccnt    <= (ccnt == 2) ? 0 : ccnt + 1;
      pclk_s  <= PCLKEN;
   end
   always @(negedge HCLK) begin
      if (watch && ((psel != psel_prev) || (penable != pen_prev)) && !pclk_s) viol++;
      psel_prev = psel;
      pen_prev  = penable;
   end

   wire        m_hready = cur3 ? hreadyout_3 : hreadyout;
   wire        m_hresp  = cur3 ? hresp_3 : hresp;
   wire [31:0] m_hrdata = cur3 ? hrdata_3 : hrdata;
   wire [3:0]  m_psel   = cur3 ? {1'b0, psel_3} : psel;
   wire        m_pen    = cur3 ? penable_3 : penable;

   int          r_nlow, r_setup, r_access;
   logic [3:0]  r_psel, r_pstrb;
   logic [15:0] r_paddr;
   logic [2:0]  r_pprot;
   logic [31:0] r_pwdata, r_rdata;
   logic        r_pwrite, r_resp_low, r_resp_end, r_anypsel;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Issues one NONSEQ transfer and records the APB/AHB view until HREADYOUT returns high.
   task automatic xfer(input bit s3, input logic [15:0] a, input bit wr, input logic [2:0] sz,
                       input logic [3:0] pr, input logic [31:0] wd);
      bit done = 0;
      cur3 = s3;
      hsel_m = !s3; hsel_3 = s3; HTRANS = 2'b10; HADDR = a; HWRITE = wr; HSIZE = sz; HPROT = pr;
      @(posedge HCLK); #1;
      hsel_m = 0; hsel_3 = 0; HTRANS = 2'b00; HWDATA = wd;
      r_nlow = 0; r_setup = 0; r_access = 0; r_anypsel = 0; r_resp_low = 0;
      r_psel = 'x; r_pstrb = 'x; r_paddr = 'x; r_pprot = 'x; r_pwdata = 'x; r_pwrite = 'x;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge HCLK);
         if (m_psel != 0) begin
            r_anypsel = 1;
            if (m_pen) r_access++;
            else begin
               r_setup++; r_psel = m_psel; r_paddr = paddr; r_pstrb = pstrb;
               r_pprot = pprot; r_pwdata = pwdata; r_pwrite = pwrite;
            end
         end
         if (m_hready) begin
            r_resp_end = m_hresp; r_rdata = m_hrdata; done = 1;
         end else begin
            r_nlow++; r_resp_low = m_hresp;
         end
      end
      if (!done) chk("xfer_timeout", m_hready, 1);
   endtask

   initial begin
      prdata[2*32 +: 32] = 32'hDEADBEEF;
      prdata[3*32 +: 32] = 32'h0BADF00D;
      prdata[1*32 +: 32] = 32'h13579BDF;
      repeat (3) @(negedge HCLK);
      chk("rst_hreadyout", hreadyout, 1); chk("rst_hresp", hresp, 0);
      chk("rst_hrdata", hrdata, 0);       chk("rst_psel", psel, 0);
      chk("rst_penable", penable, 0);     chk("rst_paddr", paddr, 0);
      chk("rst_pstrb", pstrb, 0);         chk("rst_pprot", pprot, 0);
      chk("rst_apbactive", apbactive, 0); chk("rst_pwdata", pwdata, 0);
      HRESETn = 1;
      @(negedge HCLK);

      // Idle/busy transfers and deselected NONSEQ must not start anything.
      hsel_m = 1; HTRANS = 2'b01; HADDR = 16'h1000;
      @(negedge HCLK);
      chk("busy_ready", hreadyout, 1); chk("busy_apbactive", apbactive, 0);
      hsel_m = 0; HTRANS = 2'b10;
      @(negedge HCLK);
      chk("nosel_apbactive", apbactive, 0); chk("nosel_psel", psel, 0);
      HTRANS = 2'b00;

      xfer(0, 16'h1004, 1, 3'd2, 4'b0011, 32'hA5A51234);
      chk("wr_nlow", r_nlow, 3);       chk("wr_psel", r_psel, 4'b0010);
      chk("wr_setup", r_setup, 1);     chk("wr_access", r_access, 1);
      chk("wr_paddr", r_paddr, 16'h1004); chk("wr_pstrb", r_pstrb, 4'hF);
      chk("wr_pwdata", r_pwdata, 32'hA5A51234); chk("wr_pwrite", r_pwrite, 1);
      chk("wr_pprot", r_pprot, 3'b001); chk("wr_resp", r_resp_end, 0);

      wait_n = 2;
      xfer(0, 16'h2008, 0, 3'd2, 4'b0000, 32'h0);
      chk("rd_nlow", r_nlow, 5);       chk("rd_rdata", r_rdata, 32'hDEADBEEF);
      chk("rd_resp", r_resp_end, 0);   chk("rd_psel", r_psel, 4'b0100);
      chk("rd_pstrb", r_pstrb, 4'h0);  chk("rd_access", r_access, 3);
      chk("rd_pprot", r_pprot, 3'b100); chk("rd_paddr", r_paddr, 16'h2008);
      wait_n = 0;

      xfer(0, 16'h0003, 1, 3'd0, 4'b0000, 32'h11000000);
      chk("byte3_pstrb", r_pstrb, 4'b1000); chk("byte3_paddr", r_paddr, 16'h0000);
      xfer(0, 16'h0001, 1, 3'd0, 4'b0000, 32'h00002200);
      chk("byte1_pstrb", r_pstrb, 4'b0010);
      xfer(0, 16'h0002, 1, 3'd1, 4'b0000, 32'h33330000);
      chk("half2_pstrb", r_pstrb, 4'b1100);

      // Slave error, then a new transfer launched in the second ERROR cycle.
      pslverr = 4'b1000;
      xfer(0, 16'h3000, 0, 3'd2, 4'b0000, 32'h0);
      chk("err_nlow", r_nlow, 4);       chk("err_resp_low", r_resp_low, 1);
      chk("err_resp_end", r_resp_end, 1); chk("err_rdata", r_rdata, 32'h0BADF00D);
      xfer(0, 16'h0010, 1, 3'd2, 4'b0000, 32'hCAFE0001);
      chk("err2_next_nlow", r_nlow, 3); chk("err2_next_resp", r_resp_end, 0);
      chk("err2_next_psel", r_psel, 4'b0001);
      pslverr = 4'b0000;

      div3 = 1; watch = 1;
      xfer(0, 16'h1020, 0, 3'd2, 4'b0000, 32'h0);
      chk("div3_setup", r_setup, 3);  chk("div3_access", r_access, 3);
      chk("div3_rdata", r_rdata, 32'h13579BDF);
      chk("div3_viol", viol, 0);
      watch = 0; div3 = 0;
      @(negedge HCLK);

      xfer(1, 16'h3000, 0, 3'd2, 4'b0000, 32'h0);
      chk("dec_anypsel", r_anypsel, 0); chk("dec_nlow", r_nlow, 2);
      chk("dec_resp_low", r_resp_low, 1); chk("dec_resp_end", r_resp_end, 1);
      cur3 = 0;
      @(negedge HCLK);

      // Reset asserted while a slave is stalling in ACCESS.
      wait_n = 1000;
      hsel_m = 1; HTRANS = 2'b10; HADDR = 16'h2004; HWRITE = 1; HSIZE = 3'd2;
      @(posedge HCLK); #1;
      hsel_m = 0; HTRANS = 2'b00; HWDATA = 32'h77777777;
      for (int i = 0; i < 20 && !penable; i++) @(negedge HCLK);
      chk("rst_reach_access", penable, 1);
      HRESETn = 0; #1;
      chk("arst_psel", psel, 0);         chk("arst_penable", penable, 0);
      chk("arst_hreadyout", hreadyout, 1); chk("arst_apbactive", apbactive, 0);
      chk("arst_paddr", paddr, 0);       chk("arst_pwdata", pwdata, 0);
      @(negedge HCLK);
      HRESETn = 1; wait_n = 0;
      @(negedge HCLK);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
